// File: rtl/grf.sv
// grf: 32 x 32-bit MIPS register file, two combinational read ports, one write port.
// Optional macro GRF_BYPASS_EN forwards WD to a read port reading the register being written.
module grf (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [31:0] WPC,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] wr_count
);

  logic [31:0] regs [32];
  logic        wr;

  // $0 writes are discarded entirely: no state, no count, no trace
  assign wr = WE && (A3 != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (wr) begin
      regs[A3] <= WD;
      wr_count <= wr_count + 32'd1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && wr) begin
      $display("@%h: $%d <= %h", WPC, A3, WD);
    end
  end
`endif

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (A1 != '0) begin
      RD1 = regs[A1];
    end
    if (A2 != '0) begin
      RD2 = regs[A2];
    end
`ifdef GRF_BYPASS_EN
    if (wr && (A3 == A1)) begin
      RD1 = WD;
    end
    if (wr && (A3 == A2)) begin
      RD2 = WD;
    end
`endif
  end

endmodule
